// File: rtl/parametric_trigger.sv
// parametric_trigger: relaunches one actor until it stops making progress; reports stats and sleep timeouts.
module parametric_trigger #(
  parameter string MODE = "ACTOR_TRIGGER",
  parameter int NUM_PREDICATES = 1,
  parameter bit PRED_REDUCE_AND = 1'b1,
  parameter int RETURN_WIDTH = 32,
  parameter logic [RETURN_WIDTH-1:0] EXECUTED_CODE = RETURN_WIDTH'(1),
  parameter int IDLE_THRESHOLD = 1,
  parameter int SLEEP_TIMEOUT = 0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_start,
  output logic                      ap_done,
  output logic                      ap_ready,
  output logic                      ap_idle,
  input  logic                      network_idle,
  input  logic [RETURN_WIDTH-1:0]   actor_return,
  input  logic                      actor_done,
  input  logic                      actor_idle,
  input  logic [NUM_PREDICATES-1:0] actor_launch_predicate,
  output logic                      actor_start,
  output logic [COUNT_WIDTH-1:0]    invocation_count,
  output logic [COUNT_WIDTH-1:0]    executed_count,
  output logic                      timed_out
);
  localparam bit ACTOR = MODE == "ACTOR_TRIGGER";
  typedef enum logic [2:0] {IDLE, SLEEP, LAUNCH, WAIT, DONE} state_t;
  state_t state;
  logic [31:0] idle_streak, sleep_cnt;
  logic to_flag, pred, executed, streak_hit, timeout_hit;
  always_comb begin
    pred = ACTOR ? 1'b1 : PRED_REDUCE_AND ? &actor_launch_predicate : |actor_launch_predicate;
    executed = actor_return == EXECUTED_CODE;
    streak_hit = ({1'b0, idle_streak} + 33'd1) >= 33'(IDLE_THRESHOLD);
    timeout_hit = (SLEEP_TIMEOUT > 0) && !pred && sleep_cnt == 32'(SLEEP_TIMEOUT - 1);
  end
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      state <= IDLE;
      invocation_count <= '0;
      executed_count <= '0;
      idle_streak <= '0;
      sleep_cnt <= '0;
      to_flag <= 1'b0;
    end else
      case (state)
        IDLE: if (ap_start) begin
          state <= SLEEP;
          invocation_count <= '0;
          executed_count <= '0;
          idle_streak <= '0;
          sleep_cnt <= '0;
        end
        SLEEP: if (actor_idle && pred) begin
          state <= LAUNCH;
          sleep_cnt <= '0;
        end else if (timeout_hit) begin
          state <= DONE;
          to_flag <= 1'b1;
        end else
          sleep_cnt <= &sleep_cnt ? sleep_cnt : sleep_cnt + 1'b1;
        LAUNCH: begin
          state <= WAIT;
          invocation_count <= &invocation_count ? invocation_count : invocation_count + 1'b1;
        end
        WAIT: if (actor_done) begin
          if (executed) begin
            executed_count <= &executed_count ? executed_count : executed_count + 1'b1;
            idle_streak <= '0;
            state <= SLEEP;
          end else begin
            idle_streak <= &idle_streak ? idle_streak : idle_streak + 1'b1;
            state <= streak_hit && (network_idle || !ACTOR) ? DONE : SLEEP;
          end
        end
        default: begin
          state <= IDLE;
          to_flag <= 1'b0;
        end
      endcase
  assign ap_done = state == DONE;
  assign ap_ready = ap_done;
  assign ap_idle = state == IDLE;
  assign actor_start = state == LAUNCH;
  assign timed_out = ap_done && to_flag;
endmodule

// File: tb/tb_parametric_trigger.sv
// tb_parametric_trigger: directed scenarios over five differently configured trigger instances.
module tb_parametric_trigger;
  logic clk = 1'b0, rst = 1'b1, network_idle = 1'b1, actor_done = 1'b0, actor_idle = 1'b1;
  logic [31:0] actor_return = '0;
  logic [2:0] pred = '0;
  logic [4:0] start = '0, done, ready, idle, astart, tmo;
  logic [31:0] inv [5];
  logic [31:0] exe [5];
  int cmp = 0, err = 0;
  always #5 clk = ~clk;
  // 0: actor/thr1, 1: input AND x3, 2: input OR x3, 3: actor/thr3, 4: output/timeout 8
  parametric_trigger #(.MODE("ACTOR_TRIGGER")) u0 (.ap_clk(clk), .ap_rst(rst), .ap_start(start[0]),
    .ap_done(done[0]), .ap_ready(ready[0]), .ap_idle(idle[0]), .network_idle(network_idle),
    .actor_return(actor_return), .actor_done(actor_done), .actor_idle(actor_idle),
    .actor_launch_predicate(pred[0]), .actor_start(astart[0]), .invocation_count(inv[0]),
    .executed_count(exe[0]), .timed_out(tmo[0]));
  parametric_trigger #(.MODE("INPUT_TRIGGER"), .NUM_PREDICATES(3), .PRED_REDUCE_AND(1'b1)) u1 (.ap_clk(clk),
    .ap_rst(rst), .ap_start(start[1]), .ap_done(done[1]), .ap_ready(ready[1]), .ap_idle(idle[1]),
    .network_idle(network_idle), .actor_return(actor_return), .actor_done(actor_done), .actor_idle(actor_idle),
    .actor_launch_predicate(pred), .actor_start(astart[1]), .invocation_count(inv[1]),
    .executed_count(exe[1]), .timed_out(tmo[1]));
  parametric_trigger #(.MODE("INPUT_TRIGGER"), .NUM_PREDICATES(3), .PRED_REDUCE_AND(1'b0)) u2 (.ap_clk(clk),
    .ap_rst(rst), .ap_start(start[2]), .ap_done(done[2]), .ap_ready(ready[2]), .ap_idle(idle[2]),
    .network_idle(network_idle), .actor_return(actor_return), .actor_done(actor_done), .actor_idle(actor_idle),
    .actor_launch_predicate(pred), .actor_start(astart[2]), .invocation_count(inv[2]),
    .executed_count(exe[2]), .timed_out(tmo[2]));
  parametric_trigger #(.MODE("ACTOR_TRIGGER"), .IDLE_THRESHOLD(3)) u3 (.ap_clk(clk), .ap_rst(rst),
    .ap_start(start[3]), .ap_done(done[3]), .ap_ready(ready[3]), .ap_idle(idle[3]), .network_idle(network_idle),
    .actor_return(actor_return), .actor_done(actor_done), .actor_idle(actor_idle),
    .actor_launch_predicate(pred[0]), .actor_start(astart[3]), .invocation_count(inv[3]),
    .executed_count(exe[3]), .timed_out(tmo[3]));
  parametric_trigger #(.MODE("OUTPUT_TRIGGER"), .SLEEP_TIMEOUT(8)) u4 (.ap_clk(clk), .ap_rst(rst),
    .ap_start(start[4]), .ap_done(done[4]), .ap_ready(ready[4]), .ap_idle(idle[4]), .network_idle(network_idle),
    .actor_return(actor_return), .actor_done(actor_done), .actor_idle(actor_idle),
    .actor_launch_predicate(pred[0]), .actor_start(astart[4]), .invocation_count(inv[4]),
    .executed_count(exe[4]), .timed_out(tmo[4]));

  task automatic kick(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // waits (bounded) for the launch, then answers one cycle later with a single actor_done
  task automatic serve(input int k, input logic [31:0] r);
    int n;
    n = 0;
    while (astart[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (astart[k] !== 1'b1) begin
      err++;
      $display("FAIL launch_wait inst %0d: actor_start=%b required 1", k, astart[k]);
    end
    @(negedge clk);
    actor_done = 1'b1;
    actor_return = r;
    @(negedge clk);
    actor_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cmp++;
      if ({idle[k], done[k], ready[k], astart[k], tmo[k]} !== 5'b10000 || inv[k] !== 0 || exe[k] !== 0) begin
        err++;
        $display("FAIL reset inst %0d: idle/done/ready/start/tmo=%b inv=%0d exe=%0d required 10000 0 0",
                 k, {idle[k], done[k], ready[k], astart[k], tmo[k]}, inv[k], exe[k]);
      end
    end
  endtask

  task automatic test_actor_run;
    kick(0);
    cmp++;
    if (astart[0] !== 1'b0 || idle[0] !== 1'b0) begin
      err++;
      $display("FAIL latency_sleep: start=%b idle=%b required 0 0", astart[0], idle[0]);
    end
    @(negedge clk);
    cmp++;
    if (astart[0] !== 1'b1) begin
      err++;
      $display("FAIL latency_launch: start=%b required 1", astart[0]);
    end
    for (int i = 0; i < 3; i++) begin
      serve(0, 32'd1);
      cmp++;
      if (done[0] !== 1'b0) begin
        err++;
        $display("FAIL exec_no_done %0d: done=%b required 0", i, done[0]);
      end
    end
    serve(0, 32'd0);
    cmp++;
    if ({done[0], ready[0], tmo[0]} !== 3'b110 || inv[0] !== 4 || exe[0] !== 3) begin
      err++;
      $display("FAIL actor_finish: done/ready/tmo=%b inv=%0d exe=%0d required 110 4 3",
               {done[0], ready[0], tmo[0]}, inv[0], exe[0]);
    end
    @(negedge clk);
    cmp++;
    if (done[0] !== 1'b0 || idle[0] !== 1'b1 || inv[0] !== 4 || exe[0] !== 3) begin
      err++;
      $display("FAIL hold_after_done: done=%b idle=%b inv=%0d exe=%0d required 0 1 4 3", done[0], idle[0], inv[0], exe[0]);
    end
  endtask

  task automatic test_network_busy;
    network_idle = 1'b0;
    kick(0);
    for (int i = 0; i < 2; i++) begin
      serve(0, 32'd0);
      cmp++;
      if (done[0] !== 1'b0) begin
        err++;
        $display("FAIL net_busy %0d: done=%b required 0", i, done[0]);
      end
    end
    network_idle = 1'b1;
    serve(0, 32'd0);
    cmp++;
    if (done[0] !== 1'b1 || inv[0] !== 3 || exe[0] !== 0) begin
      err++;
      $display("FAIL net_idle_finish: done=%b inv=%0d exe=%0d required 1 3 0", done[0], inv[0], exe[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_predicates;
    int seen;
    network_idle = 1'b0;
    pred = 3'b011;
    kick(1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(astart[1]);
    end
    cmp++;
    if (seen != 0) begin
      err++;
      $display("FAIL and_blocked: launches=%0d required 0", seen);
    end
    pred = 3'b111;
    @(negedge clk);
    cmp++;
    if (astart[1] !== 1'b1) begin
      err++;
      $display("FAIL and_launch: start=%b required 1", astart[1]);
    end
    serve(1, 32'd0);
    cmp++;
    if (done[1] !== 1'b1 || tmo[1] !== 1'b0 || inv[1] !== 1) begin
      err++;
      $display("FAIL and_finish: done=%b tmo=%b inv=%0d required 1 0 1", done[1], tmo[1], inv[1]);
    end
    @(negedge clk);
    pred = 3'b001;
    kick(2);
    @(negedge clk);
    cmp++;
    if (astart[2] !== 1'b1) begin
      err++;
      $display("FAIL or_launch: start=%b required 1", astart[2]);
    end
    serve(2, 32'd0);
    cmp++;
    if (done[2] !== 1'b1 || inv[2] !== 1) begin
      err++;
      $display("FAIL or_finish: done=%b inv=%0d required 1 1", done[2], inv[2]);
    end
    @(negedge clk);
    network_idle = 1'b1;
  endtask

  task automatic test_idle_threshold;
    logic [31:0] seq [6];
    seq = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    kick(3);
    for (int i = 0; i < 6; i++) begin
      serve(3, seq[i]);
      cmp++;
      if (done[3] !== (i == 5)) begin
        err++;
        $display("FAIL streak return %0d: done=%b required %b", i, done[3], i == 5);
      end
    end
    cmp++;
    if (inv[3] !== 6 || exe[3] !== 1) begin
      err++;
      $display("FAIL streak_counts: inv=%0d exe=%0d required 6 1", inv[3], exe[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    pred = 3'b000;
    kick(4);
    repeat (7) @(negedge clk);
    cmp++;
    if (done[4] !== 1'b0 || tmo[4] !== 1'b0) begin
      err++;
      $display("FAIL timeout_early: done=%b tmo=%b required 0 0", done[4], tmo[4]);
    end
    @(negedge clk);
    cmp++;
    if ({done[4], ready[4], tmo[4]} !== 3'b111 || inv[4] !== 0) begin
      err++;
      $display("FAIL timeout_fire: done/ready/tmo=%b inv=%0d required 111 0", {done[4], ready[4], tmo[4]}, inv[4]);
    end
    @(negedge clk);
    cmp++;
    if (done[4] !== 1'b0 || tmo[4] !== 1'b0 || idle[4] !== 1'b1) begin
      err++;
      $display("FAIL timeout_clear: done=%b tmo=%b idle=%b required 0 0 1", done[4], tmo[4], idle[4]);
    end
  endtask

  task automatic test_reset_in_wait;
    kick(0);
    repeat (2) @(negedge clk);
    actor_done = 1'b1;
    actor_return = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    actor_done = 1'b0;
    cmp++;
    if (idle[0] !== 1'b1 || done[0] !== 1'b0 || inv[0] !== 0 || exe[0] !== 0) begin
      err++;
      $display("FAIL reset_wait: idle=%b done=%b inv=%0d exe=%0d required 1 0 0 0", idle[0], done[0], inv[0], exe[0]);
    end
    @(negedge clk);
    cmp++;
    if (done[0] !== 1'b0 || idle[0] !== 1'b1) begin
      err++;
      $display("FAIL reset_wait_quiet: done=%b idle=%b required 0 1", done[0], idle[0]);
    end
    kick(0);
    serve(0, 32'd0);
    cmp++;
    if (done[0] !== 1'b1 || inv[0] !== 1) begin
      err++;
      $display("FAIL rerun_after_reset: done=%b inv=%0d required 1 1", done[0], inv[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_actor_run;
    test_network_busy;
    test_predicates;
    test_idle_threshold;
    test_timeout;
    test_reset_in_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/parametric_trigger.md
Name: parametric_trigger

Overview:
Next-generation actor trigger. It repeatedly launches one HLS actor until the actor reports no further progress, then signals completion upward. It generalises the existing trigger in four ways: a multi-bit launch predicate with selectable AND/OR reduction, a configurable count of consecutive idle returns before finishing, a sleep timeout, and invocation/execution statistics counters. It sits between the network controller (ap_* handshake) and a single actor's ap_ctrl interface.

Parameters:
MODE, ACTOR_TRIGGER, one of ACTOR_TRIGGER, INPUT_TRIGGER, OUTPUT_TRIGGER.
NUM_PREDICATES, 1, width of actor_launch_predicate (>=1).
PRED_REDUCE_AND, 1, 1: predicate = AND of bits; 0: OR of bits.
RETURN_WIDTH, 32, width of actor_return.
EXECUTED_CODE, 1, actor_return value meaning "executed at least one action".
IDLE_THRESHOLD, 1, consecutive non-executed returns required to finish (>=1).
SLEEP_TIMEOUT, 0, SLEEP cycles with false predicate before forced finish; 0 disables.
COUNT_WIDTH, 32, width of the statistics counters.

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous reset, active-high
ap_start  in  1  request to run the trigger
ap_done  out  1  one-cycle completion pulse
ap_ready  out  1  equal to ap_done
ap_idle  out  1  high in IDLE
network_idle  in  1  all network FIFOs quiescent
actor_return  in  RETURN_WIDTH  actor return code, valid with actor_done
actor_done  in  1  actor invocation finished
actor_idle  in  1  actor ap_idle
actor_launch_predicate  in  NUM_PREDICATES  per-port launch conditions
actor_start  out  1  actor ap_start
invocation_count  out  COUNT_WIDTH  launches since last accepted ap_start
executed_count  out  COUNT_WIDTH  returns equal to EXECUTED_CODE since last accepted ap_start
timed_out  out  1  high with ap_done when finish was caused by SLEEP_TIMEOUT

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is synchronous and active-high.
- Reset values: state IDLE, all counters 0. ap_idle=1; ap_done, ap_ready, actor_start and timed_out are 0.
- pred: the reduction of actor_launch_predicate, AND or OR per PRED_REDUCE_AND. Forced to 1 when MODE=ACTOR_TRIGGER.
- executed: actor_return == EXECUTED_CODE, full-width compare.
- States: IDLE, SLEEP, LAUNCH, WAIT, DONE. All outputs are registered-state decodes.
- IDLE:
  - ap_start=1 goes to SLEEP.
  - On that same edge: invocation_count, executed_count, idle_streak and sleep_cnt clear to 0.
  - ap_start in any other state is ignored.
- SLEEP:
  - actor_idle && pred goes to LAUNCH, and sleep_cnt clears.
  - Otherwise sleep_cnt increments (saturating).
  - If SLEEP_TIMEOUT>0 and sleep_cnt==SLEEP_TIMEOUT-1 while pred=0, go to DONE with the timeout flag set.
  - Launch takes priority over timeout on the same cycle.
- LAUNCH: actor_start=1 for exactly one cycle. invocation_count increments (saturating at all-ones). Next state is WAIT.
- WAIT: actor_done is sampled only here; it is ignored elsewhere. On actor_done:
  - executed=1: executed_count increments (saturating), idle_streak clears to 0, next state SLEEP.
  - executed=0: idle_streak increments (saturating).
    - Go to DONE if (idle_streak+1 >= IDLE_THRESHOLD) and (network_idle || MODE!=ACTOR_TRIGGER).
    - Otherwise go to SLEEP.
- DONE: ap_done=ap_ready=1 for one cycle; timed_out=1 only if the timeout path was taken. Next state IDLE, and the timeout flag clears.
- ap_idle=1 only in IDLE. Counters hold their values after DONE until the next accepted ap_start.
- actor_start is never asserted while actor_idle was 0 on the transition cycle into LAUNCH.
- Reset asserted in any state returns to IDLE on the next edge. Any pending actor_done is discarded.
- Latency:
  - ap_start to first actor_start: 2 cycles minimum (IDLE to SLEEP to LAUNCH).
  - actor_done (finishing) to ap_done: 1 cycle.

Test Plan:
- ACTOR mode, IDLE_THRESHOLD=1, network_idle=1: ap_start, then actor returns EXECUTED_CODE three times, then 0 → four actor_start pulses; ap_done one cycle after the 4th actor_done; invocation_count=4, executed_count=3, timed_out=0.
- ACTOR mode, network_idle=0 while actor returns 0 twice, then network_idle=1 and return 0 → no ap_done until the third non-executed return; invocation_count=3.
- INPUT mode, NUM_PREDICATES=3, AND reduction, predicate=3'b011 for 20 cycles then 3'b111 → no actor_start until the cycle after 3'b111 is seen in SLEEP. Repeat with OR reduction and 3'b001 → launch is immediate.
- IDLE_THRESHOLD=3, returns 0,0,EXECUTED,0,0,0 → the streak resets on EXECUTED; ap_done only after the 6th return; invocation_count=6.
- SLEEP_TIMEOUT=8, OUTPUT mode, predicate held 0 after ap_start → ap_done and timed_out both high exactly 8 cycles after entering SLEEP; invocation_count=0.
- Reset asserted during WAIT with actor_done high on the same cycle → next cycle IDLE, ap_idle=1, counters 0, no ap_done; a subsequent ap_start runs normally.
